// File: rtl/bus_arbiter_2m_pkg.sv
// Shared definitions for the two-master data-bus arbiter: state encodings,
// arbitration policy codes and the tie-break helper used by the FSM.
package bus_arbiter_2m_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_GNT0 = 2'd1,
    ARB_GNT1 = 2'd2,
    ARB_TURN = 2'd3
  } arb_state_e;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  localparam int BUS_AW = 8;
  localparam int BUS_DW = 8;

  // Picks the next owner from the raw requests; last_owner breaks round-robin
  // ties, starved lets master 1 win a fixed-priority tie.
  function automatic arb_state_e arbitrate(
    input logic req0,
    input logic req1,
    input logic last_owner,
    input logic fixed_mode,
    input logic starved
  );
    arb_state_e nxt;
    if (req0 && req1) begin
      if (fixed_mode) begin
        nxt = starved ? ARB_GNT1 : ARB_GNT0;
      end else begin
        nxt = last_owner ? ARB_GNT0 : ARB_GNT1;
      end
    end else if (req0) begin
      nxt = ARB_GNT0;
    end else if (req1) begin
      nxt = ARB_GNT1;
    end else begin
      nxt = ARB_IDLE;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/bus_mux_2m.sv
// Combinational AND-OR slave mux: only the granted master's fields reach the
// slave bus, and everything is zero when nobody holds a grant.
module bus_mux_2m
  import bus_arbiter_2m_pkg::*;
(
  input  logic              grant0,
  input  logic              grant1,
  input  logic [BUS_AW-1:0] m0_addr,
  input  logic              m0_wr,
  input  logic              m0_rd,
  input  logic [BUS_DW-1:0] m0_data,
  input  logic [BUS_AW-1:0] m1_addr,
  input  logic              m1_wr,
  input  logic              m1_rd,
  input  logic [BUS_DW-1:0] m1_data,
  output logic [BUS_AW-1:0] s_addr,
  output logic              s_wr,
  output logic              s_rd,
  output logic [BUS_DW-1:0] s_data
);

  assign s_addr = ({BUS_AW{grant0}} & m0_addr) | ({BUS_AW{grant1}} & m1_addr);
  assign s_data = ({BUS_DW{grant0}} & m0_data) | ({BUS_DW{grant1}} & m1_data);
  assign s_wr   = (grant0 & m0_wr) | (grant1 & m1_wr);
  assign s_rd   = (grant0 & m0_rd) | (grant1 & m1_rd);

endmodule

// File: rtl/bus_arbiter_2m.sv
// Two-master data-memory bus arbiter: ownership FSM with optional turnaround,
// starvation escape for master 1 in fixed-priority mode, and strobe-violation flag.
module bus_arbiter_2m
  import bus_arbiter_2m_pkg::*;
#(
  parameter int         PRIORITY_MODE = 0,
  parameter int         TURNAROUND    = 1,
  parameter logic [7:0] MAX_WAIT      = 8'd255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_bus_req,
  output logic              m0_bus_grant,
  input  logic [BUS_AW-1:0] m0_mst2slv_addr,
  input  logic              m0_mst2slv_wr,
  input  logic              m0_mst2slv_rd,
  input  logic [BUS_DW-1:0] m0_mst2slv_data,
  output logic [BUS_DW-1:0] m0_slv2mst_data,
  input  logic              m1_bus_req,
  output logic              m1_bus_grant,
  input  logic [BUS_AW-1:0] m1_mst2slv_addr,
  input  logic              m1_mst2slv_wr,
  input  logic              m1_mst2slv_rd,
  input  logic [BUS_DW-1:0] m1_mst2slv_data,
  output logic [BUS_DW-1:0] m1_slv2mst_data,
  output logic [BUS_AW-1:0] s_mst2slv_addr,
  output logic              s_mst2slv_wr,
  output logic              s_mst2slv_rd,
  output logic [BUS_DW-1:0] s_mst2slv_data,
  input  logic [BUS_DW-1:0] s_slv2mst_data,
  output logic              bus_err,
  output logic [1:0]        arb_state
);

  localparam logic FIXED_MODE = (PRIORITY_MODE == ARB_FIXED);
  localparam logic USE_TURN   = (TURNAROUND == 1);

  arb_state_e state_q, state_d;
  logic       last_owner_q, last_owner_d;
  logic [7:0] starve_cnt_q, starve_cnt_d;
  logic       bus_err_q, bus_err_d;
  logic       starved_s;

  assign starved_s = (starve_cnt_q == MAX_WAIT);

  // Next-state and last-owner logic; an owner is never preempted while requesting.
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    case (state_q)
      ARB_IDLE, ARB_TURN: begin
        state_d = arbitrate(m0_bus_req, m1_bus_req, last_owner_q, FIXED_MODE, starved_s);
      end
      ARB_GNT0: begin
        if (!m0_bus_req) begin
          last_owner_d = 1'b0;
          if (USE_TURN) begin
            state_d = ARB_TURN;
          end else begin
            state_d = arbitrate(1'b0, m1_bus_req, 1'b0, FIXED_MODE, starved_s);
          end
        end else begin
          state_d = ARB_GNT0;
        end
      end
      ARB_GNT1: begin
        if (!m1_bus_req) begin
          last_owner_d = 1'b1;
          if (USE_TURN) begin
            state_d = ARB_TURN;
          end else begin
            state_d = arbitrate(m0_bus_req, 1'b0, 1'b1, FIXED_MODE, starved_s);
          end
        end else begin
          state_d = ARB_GNT1;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // Starvation counter: counts master 1 waiting cycles, saturating at MAX_WAIT.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!FIXED_MODE) begin
      starve_cnt_d = 8'd0;
    end else if (!m1_bus_req) begin
      starve_cnt_d = 8'd0;
    end else if ((state_q == ARB_GNT1) || (state_d == ARB_GNT1)) begin
      starve_cnt_d = 8'd0;
    end else if (starved_s) begin
      starve_cnt_d = starve_cnt_q;
    end else begin
      starve_cnt_d = starve_cnt_q + 8'd1;
    end
  end

  // A strobe from a master that does not currently own the bus is a violation.
  always_comb begin
    bus_err_d = 1'b0;
    if (((m0_mst2slv_wr | m0_mst2slv_rd) && (state_q != ARB_GNT0)) ||
        ((m1_mst2slv_wr | m1_mst2slv_rd) && (state_q != ARB_GNT1))) begin
      bus_err_d = 1'b1;
    end else begin
      bus_err_d = 1'b0;
    end
  end

  // State registers; last_owner resets to 1 so master 0 wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ARB_IDLE;
      last_owner_q <= 1'b1;
      starve_cnt_q <= 8'd0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      starve_cnt_q <= starve_cnt_d;
      bus_err_q    <= bus_err_d;
    end
  end

  assign m0_bus_grant    = (state_q == ARB_GNT0);
  assign m1_bus_grant    = (state_q == ARB_GNT1);
  assign arb_state       = state_q;
  assign bus_err         = bus_err_q;
  assign m0_slv2mst_data = s_slv2mst_data;
  assign m1_slv2mst_data = s_slv2mst_data;

  bus_mux_2m u_mux (
    .grant0  (m0_bus_grant),
    .grant1  (m1_bus_grant),
    .m0_addr (m0_mst2slv_addr),
    .m0_wr   (m0_mst2slv_wr),
    .m0_rd   (m0_mst2slv_rd),
    .m0_data (m0_mst2slv_data),
    .m1_addr (m1_mst2slv_addr),
    .m1_wr   (m1_mst2slv_wr),
    .m1_rd   (m1_mst2slv_rd),
    .m1_data (m1_mst2slv_data),
    .s_addr  (s_mst2slv_addr),
    .s_wr    (s_mst2slv_wr),
    .s_rd    (s_mst2slv_rd),
    .s_data  (s_mst2slv_data)
  );

endmodule

// File: tb/tb_bus_arbiter_2m.sv
// Directed bench for bus_arbiter_2m: a round-robin instance and a fixed-priority
// instance (MAX_WAIT = 4) share one set of master/slave stimulus.
module tb_bus_arbiter_2m;

  logic       clk = 1'b0;
  logic       rst;
  logic       m0_req, m0_wr, m0_rd, m1_req, m1_wr, m1_rd;
  logic [7:0] m0_addr, m0_data, m1_addr, m1_data, s_rdata;

  logic       rr_g0, rr_g1, rr_s_wr, rr_s_rd, rr_err;
  logic [7:0] rr_m0_rdata, rr_m1_rdata, rr_s_addr, rr_s_data;
  logic [1:0] rr_state;
  logic       fx_g0, fx_g1, fx_s_wr, fx_s_rd, fx_err;
  logic [7:0] fx_m0_rdata, fx_m1_rdata, fx_s_addr, fx_s_data;
  logic [1:0] fx_state;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bus_arbiter_2m #(.PRIORITY_MODE(0), .TURNAROUND(1), .MAX_WAIT(8'd255)) dut_rr (
    .clk(clk), .rst(rst),
    .m0_bus_req(m0_req), .m0_bus_grant(rr_g0), .m0_mst2slv_addr(m0_addr),
    .m0_mst2slv_wr(m0_wr), .m0_mst2slv_rd(m0_rd), .m0_mst2slv_data(m0_data),
    .m0_slv2mst_data(rr_m0_rdata),
    .m1_bus_req(m1_req), .m1_bus_grant(rr_g1), .m1_mst2slv_addr(m1_addr),
    .m1_mst2slv_wr(m1_wr), .m1_mst2slv_rd(m1_rd), .m1_mst2slv_data(m1_data),
    .m1_slv2mst_data(rr_m1_rdata),
    .s_mst2slv_addr(rr_s_addr), .s_mst2slv_wr(rr_s_wr), .s_mst2slv_rd(rr_s_rd),
    .s_mst2slv_data(rr_s_data), .s_slv2mst_data(s_rdata),
    .bus_err(rr_err), .arb_state(rr_state)
  );

  bus_arbiter_2m #(.PRIORITY_MODE(1), .TURNAROUND(1), .MAX_WAIT(8'd4)) dut_fx (
    .clk(clk), .rst(rst),
    .m0_bus_req(m0_req), .m0_bus_grant(fx_g0), .m0_mst2slv_addr(m0_addr),
    .m0_mst2slv_wr(m0_wr), .m0_mst2slv_rd(m0_rd), .m0_mst2slv_data(m0_data),
    .m0_slv2mst_data(fx_m0_rdata),
    .m1_bus_req(m1_req), .m1_bus_grant(fx_g1), .m1_mst2slv_addr(m1_addr),
    .m1_mst2slv_wr(m1_wr), .m1_mst2slv_rd(m1_rd), .m1_mst2slv_data(m1_data),
    .m1_slv2mst_data(fx_m1_rdata),
    .s_mst2slv_addr(fx_s_addr), .s_mst2slv_wr(fx_s_wr), .s_mst2slv_rd(fx_s_rd),
    .s_mst2slv_data(fx_s_data), .s_slv2mst_data(s_rdata),
    .bus_err(fx_err), .arb_state(fx_state)
  );

  task automatic idle_inputs();
    m0_req = 1'b0; m0_wr = 1'b0; m0_rd = 1'b0; m0_addr = 8'h00; m0_data = 8'h00;
    m1_req = 1'b0; m1_wr = 1'b0; m1_rd = 1'b0; m1_addr = 8'h00; m1_data = 8'h00;
    s_rdata = 8'h00;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    m0_req = 1'b1; m1_req = 1'b1; m0_addr = 8'h5A;
    rst = 1'b1;
    tick();
    checks++; if (rr_g0 !== 1'b0) begin errors++; $display("FAIL reset_g0: got %0b want 0", rr_g0); end
    checks++; if (rr_g1 !== 1'b0) begin errors++; $display("FAIL reset_g1: got %0b want 0", rr_g1); end
    checks++; if (rr_s_addr !== 8'h00) begin errors++; $display("FAIL reset_s_addr: got %0h want 00", rr_s_addr); end
    checks++; if (rr_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", rr_state); end
    checks++; if (rr_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b want 0", rr_err); end
    rst = 1'b0;
    tick();
    checks++; if (rr_g0 !== 1'b1) begin errors++; $display("FAIL first_tie_rr_g0: got %0b want 1", rr_g0); end
    checks++; if (rr_s_addr !== 8'h5A) begin errors++; $display("FAIL first_tie_s_addr: got %0h want 5a", rr_s_addr); end
    checks++; if (fx_g0 !== 1'b1) begin errors++; $display("FAIL first_tie_fx_g0: got %0b want 1", fx_g0); end
  endtask

  task automatic test_solo();
    do_reset();
    m1_req = 1'b1;
    tick();
    checks++; if (rr_g1 !== 1'b1) begin errors++; $display("FAIL solo_g1: got %0b want 1", rr_g1); end
    checks++; if (rr_state !== 2'd2) begin errors++; $display("FAIL solo_state: got %0d want 2", rr_state); end
    m1_addr = 8'h80; m1_data = 8'hA5; m1_wr = 1'b1; s_rdata = 8'h3C;
    #1;
    checks++; if (rr_s_addr !== 8'h80) begin errors++; $display("FAIL solo_s_addr: got %0h want 80", rr_s_addr); end
    checks++; if (rr_s_data !== 8'hA5) begin errors++; $display("FAIL solo_s_data: got %0h want a5", rr_s_data); end
    checks++; if (rr_s_wr !== 1'b1) begin errors++; $display("FAIL solo_s_wr: got %0b want 1", rr_s_wr); end
    checks++; if (rr_m0_rdata !== 8'h3C) begin errors++; $display("FAIL solo_m0_rdata: got %0h want 3c", rr_m0_rdata); end
    checks++; if (rr_m1_rdata !== 8'h3C) begin errors++; $display("FAIL solo_m1_rdata: got %0h want 3c", rr_m1_rdata); end
    tick();
    checks++; if (rr_err !== 1'b0) begin errors++; $display("FAIL solo_no_err: got %0b want 0", rr_err); end
    m1_req = 1'b0; m1_wr = 1'b0;
    tick();
    checks++; if (rr_state !== 2'd3) begin errors++; $display("FAIL solo_turn: got %0d want 3", rr_state); end
    checks++; if (rr_s_addr !== 8'h00) begin errors++; $display("FAIL solo_turn_s_addr: got %0h want 00", rr_s_addr); end
    tick();
    checks++; if (rr_state !== 2'd0) begin errors++; $display("FAIL solo_idle: got %0d want 0", rr_state); end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_seq [13];
    exp_seq = '{2'd1, 2'd1, 2'd1, 2'd3, 2'd2, 2'd2, 2'd2, 2'd3,
                2'd1, 2'd1, 2'd1, 2'd3, 2'd2};
    do_reset();
    for (int e = 0; e < 13; e++) begin
      m0_req = !((e == 3) || (e == 11));
      m1_req = (e != 7);
      tick();
      checks++;
      if (rr_state !== exp_seq[e]) begin
        errors++;
        $display("FAIL rr_order edge %0d: got %0d want %0d", e, rr_state, exp_seq[e]);
      end
    end
  endtask

  task automatic test_starvation();
    logic [1:0] exp_seq [5];
    exp_seq = '{2'd1, 2'd3, 2'd1, 2'd3, 2'd2};
    do_reset();
    for (int e = 0; e < 5; e++) begin
      m0_req = ((e % 2) == 0);
      m1_req = 1'b1;
      tick();
      checks++;
      if (fx_state !== exp_seq[e]) begin
        errors++;
        $display("FAIL starve edge %0d: got %0d want %0d", e, fx_state, exp_seq[e]);
      end
    end
    checks++; if (fx_g1 !== 1'b1) begin errors++; $display("FAIL starve_g1: got %0b want 1", fx_g1); end
  endtask

  task automatic test_hold();
    logic exp_g0 [5];
    logic exp_g1 [5];
    exp_g0 = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    exp_g1 = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    for (int e = 0; e < 5; e++) begin
      m0_req = (e < 3);
      m1_req = 1'b1;
      tick();
      checks++;
      if ((rr_g0 !== exp_g0[e]) || (rr_g1 !== exp_g1[e])) begin
        errors++;
        $display("FAIL hold edge %0d: got g0=%0b g1=%0b want g0=%0b g1=%0b",
                 e, rr_g0, rr_g1, exp_g0[e], exp_g1[e]);
      end
    end
  endtask

  task automatic test_protocol_err();
    do_reset();
    m0_req = 1'b1;
    tick();
    m0_rd = 1'b1; m0_addr = 8'h10; m1_wr = 1'b1; m1_addr = 8'h99;
    #1;
    checks++; if (rr_s_wr !== 1'b0) begin errors++; $display("FAIL perr_s_wr: got %0b want 0", rr_s_wr); end
    checks++; if (rr_s_rd !== 1'b1) begin errors++; $display("FAIL perr_s_rd: got %0b want 1", rr_s_rd); end
    checks++; if (rr_s_addr !== 8'h10) begin errors++; $display("FAIL perr_s_addr: got %0h want 10", rr_s_addr); end
    tick();
    checks++; if (rr_err !== 1'b1) begin errors++; $display("FAIL perr_pulse: got %0b want 1", rr_err); end
    checks++; if (fx_err !== 1'b1) begin errors++; $display("FAIL perr_pulse_fx: got %0b want 1", fx_err); end
    m1_wr = 1'b0;
    tick();
    checks++; if (rr_err !== 1'b0) begin errors++; $display("FAIL perr_one_cycle: got %0b want 0", rr_err); end
  endtask

  task automatic test_async_reset();
    do_reset();
    m1_req = 1'b1; m1_addr = 8'h77;
    tick();
    checks++; if (rr_g1 !== 1'b1) begin errors++; $display("FAIL areset_pre_g1: got %0b want 1", rr_g1); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (rr_g1 !== 1'b0) begin errors++; $display("FAIL areset_g1: got %0b want 0", rr_g1); end
    checks++; if (rr_s_addr !== 8'h00) begin errors++; $display("FAIL areset_s_addr: got %0h want 00", rr_s_addr); end
    checks++; if (rr_state !== 2'd0) begin errors++; $display("FAIL areset_state: got %0d want 0", rr_state); end
    idle_inputs();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_solo();
    test_round_robin();
    test_starvation();
    test_hold();
    test_protocol_err();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
